button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 16 +
 rtl/button_conditioner_sync_2ff.sv | 21 ++
 rtl/button_conditioner.sv | 117 +++++++++++
 tb/tb_button_conditioner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing constants for the button conditioner.
// Defaults assume a 100 MHz clock: 10 ms debounce, 0.5 s first repeat, 0.2 s repeat rate.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DEBOUNCE_DEF      = 1000000;
    localparam int REPEAT_DELAY_DEF  = 50000000;
    localparam int REPEAT_PERIOD_DEF = 20000000;

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Two-flop synchroniser that brings the raw asynchronous button into the clock domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounces a bouncing push button into a level, a one-cycle press strobe and a press counter.
// Optional auto-repeat while held is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic       basys_clk,
    input  logic       clr,
    input  logic       btn_in,
    output logic       pulse,
    output logic       level,
    output logic [7:0] press_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Out-of-range parameters leave a visible marker block in the elaborated hierarchy.
    generate
        if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        end
    endgenerate

    logic             btn_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    sync_2ff u_sync (
        .clk   (basys_clk),
        .rst_n (clr),
        .d     (btn_in),
        .q     (btn_s)
    );

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_started;   // first repeat already issued, use the shorter period
`endif

    always_ff @(posedge basys_clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            cnt       <= '0;
            pulse     <= 1'b0;
            level     <= 1'b0;
            press_cnt <= 8'd0;
`ifdef BUTTON_AUTOREPEAT_EN
            rep_cnt     <= '0;
            rep_started <= 1'b0;
`endif
        end else begin
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= PRESSED;
                        level     <= 1'b1;
                        pulse     <= 1'b1;
                        press_cnt <= press_cnt + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PRESSED: begin
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
                        rep_cnt     <= '0;
                        rep_started <= 1'b0;
                    end else if (rep_cnt == (rep_started ? PERIOD_LAST : DELAY_LAST)) begin
                        pulse       <= 1'b1;
                        press_cnt   <= press_cnt + 8'd1;
                        rep_cnt     <= '0;
                        rep_started <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
`endif
                    end
                end

                RELEASE_WAIT: begin
                    // A bounce back to high resumes the held press without a new strobe.
                    if (btn_s) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Expectations adapt to BUTTON_AUTOREPEAT_EN when it is defined for the build.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;
    localparam int ACCEPT = D + 3;   // edge index of the acceptance strobe
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       btn = 1'b0;
    logic       pulse;
    logic       level;
    logic [7:0] press_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       btn;
        logic       pulse;
        logic       level;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .basys_clk (clk),
        .clr       (clr),
        .btn_in    (btn),
        .pulse     (pulse),
        .level     (level),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic b);
        btn = b;
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input logic b, input logic p, input logic l, input int c);
        vec_t v;
        v.btn   = b;
        v.pulse = p;
        v.level = l;
        v.cnt   = 8'(c);
        vecs.push_back(v);
    endfunction

    // Expected strobe for a clean hold; the FSM sees btn_in two edges late, so it stays PRESSED through edge hold+2.
    function automatic logic exp_pulse(input int k, input int hold);
        return (k == ACCEPT) ||
               (AR && k >= ACCEPT + RD && k <= hold + 2 && ((k - ACCEPT - RD) % RP) == 0);
    endfunction

    initial begin
        int c;
        int npulse;
        logic p;

        // Clean press held 20, then release.
        c = 0;
        for (int k = 1; k <= 30; k++) begin
            p = exp_pulse(k, 20);
            if (p) c++;
            push(k <= 20, p, (k >= ACCEPT) && (k < 20 + ACCEPT), c);
        end
        // Short bounce never reaches acceptance.
        push(1'b1, 1'b0, 1'b0, c);
        push(1'b0, 1'b0, 1'b0, c);
        push(1'b1, 1'b0, 1'b0, c);
        push(1'b0, 1'b0, 1'b0, c);
        for (int k = 1; k <= 8; k++) push(1'b0, 1'b0, 1'b0, c);
        // Held press, 2-cycle dropout, held again, release.
        for (int k = 1; k <= 12; k++) begin
            if (k == ACCEPT) c++;
            push(1'b1, k == ACCEPT, k >= ACCEPT, c);
        end
        push(1'b0, 1'b0, 1'b1, c);
        push(1'b0, 1'b0, 1'b1, c);
        for (int k = 1; k <= 8; k++) push(1'b1, 1'b0, 1'b1, c);
        for (int r = 1; r <= 10; r++) push(1'b0, 1'b0, r < ACCEPT, c);

        // Reset state.
        clr = 1'b0;
        btn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pulse", 0, {7'd0, pulse}, 8'd0);
        check("rst_level", 0, {7'd0, level}, 8'd0);
        check("rst_cnt", 0, press_cnt, 8'd0);
        clr = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].btn);
            $display("[TB] vec %0d btn=%0b pulse=%0b level=%0b cnt=%0d", i, vecs[i].btn, pulse, level, press_cnt);
            check("vec_pulse", i, {7'd0, pulse}, {7'd0, vecs[i].pulse});
            check("vec_level", i, {7'd0, level}, {7'd0, vecs[i].level});
            check("vec_cnt", i, press_cnt, vecs[i].cnt);
        end

        // Reset during PRESS_WAIT: counter cleared at once, full debounce restarts.
        for (int k = 1; k <= 4; k++) step(1'b1);
        #2 clr = 1'b0;
        #1;
        check("pw_rst_cnt", 0, press_cnt, 8'd0);
        check("pw_rst_level", 0, {7'd0, level}, 8'd0);
        @(posedge clk);
        #1 clr = 1'b1;
        for (int k = 1; k <= ACCEPT; k++) begin
            step(1'b1);
            check("pw_restart_pulse", k, {7'd0, pulse}, {7'd0, logic'(k == ACCEPT)});
        end
        check("pw_restart_level", 0, {7'd0, level}, 8'd1);
        check("pw_restart_cnt", 0, press_cnt, 8'd1);
        $display("[TB] reset in PRESS_WAIT: level=%0b cnt=%0d", level, press_cnt);

        // Reset during PRESSED: level drops without a clock edge.
        #2 clr = 1'b0;
        #1;
        check("pr_rst_level", 0, {7'd0, level}, 8'd0);
        check("pr_rst_pulse", 0, {7'd0, pulse}, 8'd0);
        check("pr_rst_cnt", 0, press_cnt, 8'd0);
        step(1'b1);
        step(1'b1);
        clr = 1'b1;
        for (int k = 1; k <= ACCEPT; k++) begin
            step(1'b1);
            check("pr_restart_pulse", k, {7'd0, pulse}, {7'd0, logic'(k == ACCEPT)});
        end
        check("pr_restart_cnt", 0, press_cnt, 8'd1);
        $display("[TB] reset in PRESSED: level=%0b cnt=%0d", level, press_cnt);
        for (int r = 1; r <= 10; r++) step(1'b0);
        check("pr_release_level", 0, {7'd0, level}, 8'd0);

        // 256 clean presses wrap the counter.
        clr = 1'b0;
        step(1'b0);
        clr = 1'b1;
        npulse = 0;
        for (int n = 0; n < 256; n++) begin
            for (int k = 1; k <= 8; k++) begin
                step(1'b1);
                if (pulse === 1'b1) npulse++;
            end
            for (int k = 1; k <= 8; k++) begin
                step(1'b0);
                if (pulse === 1'b1) npulse++;
            end
            $display("[TB] press %0d cnt=%0d", n, press_cnt);
            if (n == 254) check("wrap_cnt_255", n, press_cnt, 8'd255);
        end
        check("wrap_cnt_0", 0, press_cnt, 8'd0);
        check("wrap_pulses", 0, 8'(npulse), 8'(256));
        check("wrap_level", 0, {7'd0, level}, 8'd0);

        // Long hold: 30 cycles past acceptance.
        clr = 1'b0;
        step(1'b0);
        clr = 1'b1;
        npulse = 0;
        for (int k = 1; k <= ACCEPT + 30; k++) begin
            step(1'b1);
            if (pulse === 1'b1) npulse++;
            check("hold_pulse", k, {7'd0, pulse}, {7'd0, exp_pulse(k, ACCEPT + 40)});
        end
        check("hold_cnt", 0, press_cnt, AR ? 8'd6 : 8'd1);
        check("hold_pulses", 0, 8'(npulse), AR ? 8'd6 : 8'd1);
        $display("[TB] long hold: pulses=%0d cnt=%0d", npulse, press_cnt);
        for (int r = 1; r <= 10; r++) step(1'b0);
        check("hold_release_level", 0, {7'd0, level}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
